// File: rtl/instr_issuer.sv
// instr_issuer -- buffers 16-bit instructions in an 8-deep FIFO and issues
// them one at a time to a controller using a start/wait handshake.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          asynchronous, active-low
//   load           push load_instr this edge (ignored while full)
//   load_instr     instruction word to enqueue
//   w              controller wait flag (1 = controller idle in its wait state)
//   clear_timeout  clears the sticky timeout flag
//   s              start pulse, high for exactly the one issue cycle
//   instr          head-of-queue instruction (16'h0000 when empty)
//   opcode, op     instr[15:13], instr[12:11]
//   full, empty    FIFO occupancy flags
//   busy           handshake in progress (any state other than idle)
//   issued_count   completed-instruction counter, wraps 255->0
//   timeout        sticky watchdog flag
//   fsm_state      debug view of the handshake state (0 idle, 1 issue,
//                  2 wait-low, 3 wait-high)
//
// Handshake: from idle with a non-empty queue and w=1 the block spends one
// cycle in issue (s=1), then waits for w to fall (controller accepted) and
// rise again (controller finished). Only the rising w pops the head, so any
// watchdog abort leaves the head in place to be retried.
module instr_issuer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_instr,
  input  logic        w,
  input  logic        clear_timeout,
  output logic        s,
  output logic [15:0] instr,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic [7:0]  issued_count,
  output logic        timeout,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_LOW  = 2'd2,
    S_WAIT_HIGH = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] mem [8];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  count;
  logic [7:0]  wd;
  logic        push;
  logic        pop;
  logic        lo_expire;
  logic        hi_expire;

  assign full  = (count == 4'd8);
  assign empty = (count == 4'd0);

  // A load while full is dropped even if the head pops on the same edge.
  assign push = load && !full;
  // The queue is never empty in wait-high: the head was present at issue
  // and nothing else pops it.
  assign pop  = (state == S_WAIT_HIGH) && w;

  // Watchdog expiry: wd counts completed edges in the current state, so the
  // 4th consecutive w=1 edge in wait-low sees wd==3 and the 255th
  // consecutive w=0 edge in wait-high sees wd==254.
  assign lo_expire = (state == S_WAIT_LOW)  &&  w && (wd == 8'd3);
  assign hi_expire = (state == S_WAIT_HIGH) && !w && (wd == 8'd254);

  assign instr     = empty ? 16'h0000 : mem[rd_ptr];
  assign opcode    = instr[15:13];
  assign op        = instr[12:11];
  assign fsm_state = state;

  // Storage needs no reset: instr is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= load_instr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      count  <= 4'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      wd           <= 8'd0;
      s            <= 1'b0;
      busy         <= 1'b0;
      timeout      <= 1'b0;
      issued_count <= 8'd0;
    end else begin
      // A new expiry wins over a clear on the same edge.
      if (lo_expire || hi_expire) timeout <= 1'b1;
      else if (clear_timeout)     timeout <= 1'b0;

      case (state)
        S_IDLE: begin
          wd <= 8'd0;
          if (!empty && w) begin
            state <= S_ISSUE;
            s     <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT_LOW;
          s     <= 1'b0;
          wd    <= 8'd0;
        end
        S_WAIT_LOW: begin
          if (!w) begin
            state <= S_WAIT_HIGH;
            wd    <= 8'd0;
          end else if (lo_expire) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            wd    <= 8'd0;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        S_WAIT_HIGH: begin
          if (w) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            wd           <= 8'd0;
            issued_count <= issued_count + 8'd1;
          end else if (hi_expire) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            wd    <= 8'd0;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          s     <= 1'b0;
          busy  <= 1'b0;
          wd    <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issuer.sv
// Testbench for instr_issuer: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model of the issuer.
module tb_instr_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] load_instr;
  logic        w;
  logic        clear_timeout;
  logic        s;
  logic [15:0] instr;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic        full;
  logic        empty;
  logic        busy;
  logic [7:0]  issued_count;
  logic        timeout;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents, handshake phase
  // (0 idle, 1 issuing, 2 awaiting w low, 3 awaiting w high),
  // consecutive-cycle count in the current phase, sticky flag, issue count.
  logic [15:0] exp_q[$];
  int          m_phase;
  int          m_run;
  bit          m_to;
  int          m_issued;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  instr_issuer dut (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .load_instr    (load_instr),
    .w             (w),
    .clear_timeout (clear_timeout),
    .s             (s),
    .instr         (instr),
    .opcode        (opcode),
    .op            (op),
    .full          (full),
    .empty         (empty),
    .busy          (busy),
    .issued_count  (issued_count),
    .timeout       (timeout),
    .fsm_state     (fsm_state)
  );

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_phase  = 0;
    m_run    = 0;
    m_to     = 0;
    m_issued = 0;
  endtask

  // One rising edge of the issuer as described by its rules.
  task automatic model_edge(input logic ld, input logic [15:0] d, input logic wv, input logic clr);
    bit was_full = (exp_q.size() == 8);
    bit expire   = 0;
    bit popped   = 0;
    case (m_phase)
      0: if (exp_q.size() > 0 && wv) m_phase = 1;
      1: begin m_phase = 2; m_run = 0; end
      2: if (!wv) begin
           m_phase = 3; m_run = 0;
         end else begin
           m_run++;
           if (m_run == 4) begin expire = 1; m_phase = 0; end
         end
      default: if (wv) begin
           popped = 1; m_phase = 0;
           m_issued = (m_issued + 1) % 256;
         end else begin
           m_run++;
           if (m_run == 255) begin expire = 1; m_phase = 0; end
         end
    endcase
    if (popped) void'(exp_q.pop_front());
    if (ld && !was_full) exp_q.push_back(d);
    if (expire)   m_to = 1;
    else if (clr) m_to = 0;
  endtask

  task automatic compare_all();
    logic [15:0] ei;
    ei = (exp_q.size() > 0) ? exp_q[0] : 16'h0000;
    check("s",            s,            (m_phase == 1));
    check("busy",         busy,         (m_phase != 0));
    check("empty",        empty,        (exp_q.size() == 0));
    check("full",         full,         (exp_q.size() == 8));
    check("instr",        instr,        ei);
    check("opcode",       opcode,       ei[15:13]);
    check("op",           op,           ei[12:11]);
    check("issued_count", issued_count, m_issued[7:0]);
    check("timeout",      timeout,      m_to);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive inputs, model the rising edge, compare
  // at the next falling edge.
  task automatic cycle(input logic ld, input logic [15:0] d, input logic wv, input logic clr);
    load = ld; load_instr = d; w = wv; clear_timeout = clr;
    @(posedge clk);
    model_edge(ld, d, wv, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    load = 1'b0; load_instr = 16'h0; w = 1'b0; clear_timeout = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) begin
      @(negedge clk);
      compare_all();
    end
    reset = 1'b1;
  endtask

  // Behaves as a well-mannered controller: waits idle (w=1) for s, records
  // the presented word, drops w for low_cycles edges, then raises w for the
  // pop edge, optionally loading a new word on that same edge.
  task automatic serve_one(input int low_cycles, input logic ld, input logic [15:0] d,
                           output logic [15:0] seen);
    int guard = 0;
    seen = 16'h0;
    while (s !== 1'b1 && guard < 20) begin
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      guard++;
    end
    check("serve_s_seen", s, 1'b1);
    seen = instr;
    repeat (low_cycles) cycle(1'b0, 16'h0, 1'b0, 1'b0);
    cycle(ld, d, 1'b1, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [15:0] words[$];
    logic [15:0] seen;
    logic [15:0] word;
    int          saved;

    reset = 1'b0;
    load = 1'b0; load_instr = 16'h0; w = 1'b0; clear_timeout = 1'b0;
    apply_reset();

    // Single instruction: s two edges after the load, then w 1->0->1 pops it.
    cycle(1'b1, 16'hD105, 1'b1, 1'b0);
    check("033_no_s_yet", s, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("033_s_pulse", s, 1'b1);
    check("033_opcode", opcode, 3'b110);
    check("033_op", op, 2'b10);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    check("033_s_one_cycle", s, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("033_empty", empty, 1'b1);
    check("033_issued", issued_count, 8'd1);

    // Nine loads with w=0: the ninth is dropped, then 8 issues in order.
    apply_reset();
    words.delete();
    for (int i = 0; i < 9; i++) begin
      word = 16'($urandom);
      words.push_back(word);
      cycle(1'b1, word, 1'b0, 1'b0);
      if (i == 7) check("034_full_after_8", full, 1'b1);
    end
    check("034_full_after_9", full, 1'b1);
    for (int i = 0; i < 8; i++) begin
      serve_one($urandom_range(2, 5), 1'b0, 16'h0, seen);
      check("034_order", seen, words[i]);
    end
    check("034_issued", issued_count, 8'd8);
    check("034_empty", empty, 1'b1);

    // w stuck high after s: timeout, head retained, retried, clear.
    apply_reset();
    cycle(1'b1, 16'hA5C3, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("035_timeout", timeout, 1'b1);
    check("035_idle", busy, 1'b0);
    check("035_head", instr, 16'hA5C3);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    check("035_cleared", timeout, 1'b0);
    serve_one(3, 1'b0, 16'h0, seen);
    check("035_retry_word", seen, 16'hA5C3);
    check("035_issued", issued_count, 8'd1);

    // w stuck low after s: watchdog after 255 cycles, no pop.
    saved = m_issued;
    cycle(1'b1, 16'h3C3C, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("036_s", s, 1'b1);
    repeat (258) cycle(1'b0, 16'h0, 1'b0, 1'b0);
    check("036_timeout", timeout, 1'b1);
    check("036_issued", issued_count, saved[7:0]);
    check("036_not_empty", empty, 1'b0);
    serve_one(2, 1'b0, 16'h0, seen);
    check("036_retry_word", seen, 16'h3C3C);

    // Reset asserted between edges while waiting for w high.
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    check("037_busy_before", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("037_s", s, 1'b0);
    check("037_busy", busy, 1'b0);
    check("037_empty", empty, 1'b1);
    check("037_issued", issued_count, 8'd0);
    model_reset();
    @(negedge clk);
    w = 1'b1;
    compare_all();
    reset = 1'b1;
    repeat (3) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("037_no_pulse", s, 1'b0);

    // Fill to 7, then pop+load on the same edge to wrap the pointers.
    apply_reset();
    words.delete();
    for (int i = 0; i < 7; i++) begin
      word = 16'($urandom);
      words.push_back(word);
      cycle(1'b1, word, 1'b0, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      word = 16'($urandom);
      if (i < 3) words.push_back(word);
      serve_one(2, (i < 3), word, seen);
      check("038_order", seen, words[i]);
      if (i < 3) check("038_not_full", full, 1'b0);
    end
    check("038_empty", empty, 1'b1);
    check("038_issued", issued_count, 8'd10);

    // Random traffic.
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 99) < 35), 16'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
